// File: rtl/mca_pos_responder_if.sv
// ----------------------------------------------------------------------------
// mca_pos_responder_if
// Purpose : Micro Channel setup-cycle bus bundle between host (master) and the
//           POS responder (slave).
// Signals : cd_setup_l  card setup select, low = setup cycle
//           adl_l       address latch, low = address/status valid
//           cmd         data strobe, high during data phase
//           s0_w_l      write status, low = write
//           s1_r_l      read status, low = read
//           a[2:0]      POS register index
//           d_in[7:0]   data from host
//           d_out[7:0]  read data from card
//           d_oe        card drives d_out onto the bus
//           cd_sfdbk    selected feedback
//           cd_chrdy_l  0 = ready, 1 = insert wait
// ----------------------------------------------------------------------------
interface mca_pos_responder_if;
   logic       cd_setup_l;
   logic       adl_l;
   logic       cmd;
   logic       s0_w_l;
   logic       s1_r_l;
   logic [2:0] a;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;
   logic       cd_sfdbk;
   logic       cd_chrdy_l;

   modport master (
      output cd_setup_l, adl_l, cmd, s0_w_l, s1_r_l, a, d_in,
      input  d_out, d_oe, cd_sfdbk, cd_chrdy_l
   );

   modport slave (
      input  cd_setup_l, adl_l, cmd, s0_w_l, s1_r_l, a, d_in,
      output d_out, d_oe, cd_sfdbk, cd_chrdy_l
   );
endinterface

// File: rtl/mca_pos_responder.sv
// ----------------------------------------------------------------------------
// mca_pos_responder
// Purpose : Micro Channel POS setup-cycle responder for the Sound Blaster MCA
//           card. Returns the adapter ID on POS 0/1 and holds the writable
//           configuration bytes POS 2..5.
// Ports   : i_clk14        14.318 MHz clock, all state changes on rising edge
//           i_chreset      channel reset, asynchronous, active-high
//           bus            setup-cycle bus (slave modport)
//           o_card_en      POS2[0]
//           o_pos2..o_pos5 configuration bytes
//           o_pos_wr_stb   one-clock pulse per committed POS write
//           o_pos_wr_idx   index of the last committed write
// Options : MCA_POS_WAIT_EN  when defined, POS reads insert WAIT_CLKS
//           not-ready clocks on cd_chrdy_l and hold d_oe off until ready.
// ----------------------------------------------------------------------------
module mca_pos_responder #(
   parameter logic [15:0] CARD_ID   = 16'h5085,
   parameter int unsigned WAIT_CLKS = 2
) (
   input  logic                   i_clk14,
   input  logic                   i_chreset,
   mca_pos_responder_if.slave     bus,
   output logic                   o_card_en,
   output logic [7:0]             o_pos2,
   output logic [7:0]             o_pos3,
   output logic [7:0]             o_pos4,
   output logic [7:0]             o_pos5,
   output logic                   o_pos_wr_stb,
   output logic [2:0]             o_pos_wr_idx
);

   typedef enum logic [1:0] {
      ST_DONE = 2'd0,
      ST_IDLE = 2'd1,
      ST_ADDR = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   state_t     r_state;
   logic [2:0] r_idx;
   logic       r_rd;
   logic       r_wr;
   logic [7:0] r_wdat;
   logic [7:0] r_pos2;
   logic [7:0] r_pos3;
   logic [7:0] r_pos4;
   logic [7:0] r_pos5;
   logic [7:0] r_d_out;
   logic       r_d_oe;
   logic       r_sfdbk;
   logic       r_wr_stb;
   logic [2:0] r_wr_idx;

   logic       w_rd_sel;
   logic       w_wr_sel;
   logic       w_addr_entry;
   logic       w_cycle_end;
   logic       w_ready;
   logic [7:0] w_rd_val;

   // Both status bits low resolves to a read; neither low is a no-op cycle.
   assign w_rd_sel     = ~bus.s1_r_l;
   assign w_wr_sel     = bus.s1_r_l & ~bus.s0_w_l;
   assign w_addr_entry = (r_state == ST_IDLE) & ~bus.adl_l & ~bus.cd_setup_l;
   assign w_cycle_end  = ((r_state == ST_ADDR) & ~bus.cmd & bus.cd_setup_l) |
                         ((r_state == ST_DATA) & ~bus.cmd);

   // Read map, indexed by the address presented with ADL
   always_comb begin
      w_rd_val = 8'h00;
      case (bus.a)
         3'd0:    w_rd_val = CARD_ID[7:0];
         3'd1:    w_rd_val = CARD_ID[15:8];
         3'd2:    w_rd_val = r_pos2;
         3'd3:    w_rd_val = r_pos3;
         3'd4:    w_rd_val = r_pos4;
         3'd5:    w_rd_val = r_pos5;
         default: w_rd_val = 8'h00;
      endcase
   end

`ifdef MCA_POS_WAIT_EN
   localparam int unsigned WCW = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;

   logic           r_chrdy_l;
   logic [WCW-1:0] r_wcnt;

   // Not-ready window: asserted on read ADDR entry, held WAIT_CLKS clocks
   always_ff @(posedge i_clk14 or posedge i_chreset) begin
      if (i_chreset) begin
         r_chrdy_l <= 1'b0;
         r_wcnt    <= '0;
      end else if (w_addr_entry && w_rd_sel) begin
         r_chrdy_l <= (WAIT_CLKS != 0);
         r_wcnt    <= WCW'(WAIT_CLKS - 1);
      end else if (w_cycle_end) begin
         r_chrdy_l <= 1'b0;
      end else if (r_chrdy_l) begin
         if (r_wcnt == '0) begin
            r_chrdy_l <= 1'b0;
         end else begin
            r_wcnt <= r_wcnt - WCW'(1);
         end
      end
   end

   assign w_ready        = ~r_chrdy_l;
   assign bus.cd_chrdy_l = r_chrdy_l;
`else
   logic w_unused_wait;

   assign w_unused_wait  = (WAIT_CLKS != 0);
   assign w_ready        = 1'b1;
   assign bus.cd_chrdy_l = 1'b0;
`endif

   // Setup-cycle state machine; reset parks in DONE so an interrupted cycle
   // is ignored until cmd is seen low.
   always_ff @(posedge i_clk14 or posedge i_chreset) begin
      if (i_chreset) begin
         r_state  <= ST_DONE;
         r_idx    <= 3'd0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_wdat   <= 8'h00;
         r_pos2   <= 8'h00;
         r_pos3   <= 8'h00;
         r_pos4   <= 8'h00;
         r_pos5   <= 8'h00;
         r_d_out  <= 8'h00;
         r_d_oe   <= 1'b0;
         r_sfdbk  <= 1'b0;
         r_wr_stb <= 1'b0;
         r_wr_idx <= 3'd0;
      end else begin
         r_wr_stb <= 1'b0;
         case (r_state)
            ST_DONE: begin
               if (!bus.cmd) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (w_addr_entry) begin
                  r_state <= ST_ADDR;
                  r_idx   <= bus.a;
                  r_rd    <= w_rd_sel;
                  r_wr    <= w_wr_sel;
                  r_sfdbk <= 1'b1;
                  r_d_out <= w_rd_sel ? w_rd_val : 8'h00;
               end
            end
            ST_ADDR: begin
               if (bus.cmd) begin
                  r_state <= ST_DATA;
                  r_d_oe  <= r_rd & w_ready;
                  if (r_wr) begin
                     r_wdat <= bus.d_in;
                  end
               end else if (bus.cd_setup_l) begin
                  r_state <= ST_IDLE;
                  r_sfdbk <= 1'b0;
               end
            end
            ST_DATA: begin
               if (bus.cmd) begin
                  if (r_rd && w_ready) begin
                     r_d_oe <= 1'b1;
                  end
                  if (r_wr) begin
                     r_wdat <= bus.d_in;
                  end
               end else begin
                  r_state <= ST_DONE;
                  r_d_oe  <= 1'b0;
                  r_sfdbk <= 1'b0;
                  if (r_wr) begin
                     r_wr_stb <= 1'b1;
                     r_wr_idx <= r_idx;
                     case (r_idx)
                        3'd2:    r_pos2 <= r_wdat;
                        3'd3:    r_pos3 <= r_wdat;
                        3'd4:    r_pos4 <= r_wdat;
                        3'd5:    r_pos5 <= r_wdat;
                        default: ;
                     endcase
                  end
               end
            end
            default: r_state <= ST_DONE;
         endcase
      end
   end

   assign bus.d_out    = r_d_out;
   assign bus.d_oe     = r_d_oe;
   assign bus.cd_sfdbk = r_sfdbk;
   assign o_pos2       = r_pos2;
   assign o_pos3       = r_pos3;
   assign o_pos4       = r_pos4;
   assign o_pos5       = r_pos5;
   assign o_card_en    = r_pos2[0];
   assign o_pos_wr_stb = r_wr_stb;
   assign o_pos_wr_idx = r_wr_idx;

endmodule

// File: tb/tb_mca_pos_responder.sv
// ----------------------------------------------------------------------------
// tb_mca_pos_responder
// Purpose : directed bench for mca_pos_responder: ID reads, POS writes,
//           ignored indices, non-setup cycles, abort, mid-cycle reset and,
//           when MCA_POS_WAIT_EN is defined, read wait states.
// ----------------------------------------------------------------------------
module tb_mca_pos_responder;

`ifdef MCA_POS_WAIT_EN
   localparam bit WAITB = 1'b1;
`else
   localparam bit WAITB = 1'b0;
`endif

   logic       clk14 = 1'b0;
   logic       chreset;
   logic       card_en;
   logic [7:0] pos2, pos3, pos4, pos5;
   logic       wr_stb;
   logic [2:0] wr_idx;

   int n_checks = 0;
   int n_fail   = 0;

   mca_pos_responder_if bus ();

   mca_pos_responder dut (
      .i_clk14      (clk14),
      .i_chreset    (chreset),
      .bus          (bus),
      .o_card_en    (card_en),
      .o_pos2       (pos2),
      .o_pos3       (pos3),
      .o_pos4       (pos4),
      .o_pos5       (pos5),
      .o_pos_wr_stb (wr_stb),
      .o_pos_wr_idx (wr_idx)
   );

   always #35 clk14 = ~clk14;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk14);
      #1;
   endtask

   function automatic logic [7:0] pos_of(input logic [2:0] idx);
      case (idx)
         3'd2:    return pos2;
         3'd3:    return pos3;
         3'd4:    return pos4;
         3'd5:    return pos5;
         default: return 8'h00;
      endcase
   endfunction

   task automatic bus_idle();
      bus.cd_setup_l = 1'b1;
      bus.adl_l      = 1'b1;
      bus.cmd        = 1'b0;
      bus.s0_w_l     = 1'b1;
      bus.s1_r_l     = 1'b1;
      bus.a          = 3'd0;
      bus.d_in       = 8'h00;
   endtask

   // One full cycle: ADL clock, three cmd-high clocks, cmd-low clock, recovery clock
   task automatic pos_cycle(input bit setup_l, input bit rd_l, input bit wr_l,
                            input logic [2:0] idx, input logic [7:0] wdat,
                            input logic [7:0] exp_rd);
      bit act, is_rd, is_wr;
      act   = ~setup_l;
      is_rd = act & ~rd_l;
      is_wr = act & rd_l & ~wr_l;
      bus.cd_setup_l = setup_l;
      bus.adl_l      = 1'b0;
      bus.s1_r_l     = rd_l;
      bus.s0_w_l     = wr_l;
      bus.a          = idx;
      bus.d_in       = wdat;
      tick();
      chk("sfdbk_addr", 8'(bus.cd_sfdbk), 8'(act));
      chk("chrdy_addr", 8'(bus.cd_chrdy_l), 8'(WAITB & is_rd));
      chk("doe_addr", 8'(bus.d_oe), 8'h00);
      if (is_rd) chk("dout", bus.d_out, exp_rd);
      bus.adl_l = 1'b1;
      bus.cmd   = 1'b1;
      tick();
      chk("doe_data1", 8'(bus.d_oe), 8'(is_rd & ~WAITB));
      chk("chrdy_data1", 8'(bus.cd_chrdy_l), 8'(WAITB & is_rd));
      tick();
      chk("doe_data2", 8'(bus.d_oe), 8'(is_rd & ~WAITB));
      chk("chrdy_data2", 8'(bus.cd_chrdy_l), 8'h00);
      tick();
      chk("doe_data3", 8'(bus.d_oe), 8'(is_rd));
      chk("sfdbk_data", 8'(bus.cd_sfdbk), 8'(act));
      bus.cmd = 1'b0;
      tick();
      chk("doe_end", 8'(bus.d_oe), 8'h00);
      chk("sfdbk_end", 8'(bus.cd_sfdbk), 8'h00);
      chk("stb_pulse", 8'(wr_stb), 8'(is_wr));
      if (is_wr) begin
         chk("wr_idx", 8'(wr_idx), 8'(idx));
         if (idx >= 3'd2 && idx <= 3'd5) chk("pos_commit", pos_of(idx), wdat);
         if (idx == 3'd2) chk("card_en", 8'(card_en), 8'(wdat[0]));
      end
      bus_idle();
      tick();
      chk("stb_clear", 8'(wr_stb), 8'h00);
   endtask

   initial begin
      bus_idle();
      chreset = 1'b1;
      tick();
      tick();
      chk("rst_doe", 8'(bus.d_oe), 8'h00);
      chk("rst_dout", bus.d_out, 8'h00);
      chk("rst_sfdbk", 8'(bus.cd_sfdbk), 8'h00);
      chk("rst_chrdy", 8'(bus.cd_chrdy_l), 8'h00);
      chk("rst_pos2", pos2, 8'h00);
      chk("rst_pos5", pos5, 8'h00);
      chk("rst_card_en", 8'(card_en), 8'h00);
      chk("rst_stb", 8'(wr_stb), 8'h00);
      chk("rst_idx", 8'(wr_idx), 8'h00);
      chreset = 1'b0;
      tick();

      // Adapter ID reads
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h85);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h50);

      // Configuration writes
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd3, 8'hB2, 8'h00);
      chk("pos3_b2", pos3, 8'hB2);
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd2, 8'h01, 8'h00);
      chk("pos2_01", pos2, 8'h01);
      chk("card_en_1", 8'(card_en), 8'h01);

      // Non-setup I/O write must not touch POS
      pos_cycle(1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, 8'h00);
      chk("io_pos2", pos2, 8'h01);
      chk("io_card_en", 8'(card_en), 8'h01);

      // Writes to ID and unused indices are dropped but still strobe
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'hAA, 8'h00);
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd6, 8'hAA, 8'h00);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h85);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 8'h00);

      // Register readback
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'hB2);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h01);

      // Both status low is a read; neither low neither drives nor writes
      pos_cycle(1'b0, 1'b0, 1'b0, 3'd3, 8'h77, 8'hB2);
      chk("both_low_pos3", pos3, 8'hB2);
      pos_cycle(1'b0, 1'b1, 1'b1, 3'd5, 8'h99, 8'h00);
      chk("none_pos5", pos5, 8'h00);

      // Abort: setup released before cmd
      bus.cd_setup_l = 1'b0;
      bus.adl_l      = 1'b0;
      bus.s0_w_l     = 1'b0;
      bus.a          = 3'd2;
      bus.d_in       = 8'hFE;
      tick();
      chk("abort_sfdbk_on", 8'(bus.cd_sfdbk), 8'h01);
      bus.adl_l      = 1'b1;
      bus.cd_setup_l = 1'b1;
      bus.s0_w_l     = 1'b1;
      tick();
      chk("abort_sfdbk_off", 8'(bus.cd_sfdbk), 8'h00);
      chk("abort_stb", 8'(wr_stb), 8'h00);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h01);

      pos_cycle(1'b0, 1'b1, 1'b0, 3'd4, 8'h11, 8'h00);
      chk("pos4_11", pos4, 8'h11);

      // Reset during a read data phase
      bus.cd_setup_l = 1'b0;
      bus.adl_l      = 1'b0;
      bus.s1_r_l     = 1'b0;
      bus.a          = 3'd1;
      tick();
      bus.adl_l = 1'b1;
      bus.cmd   = 1'b1;
      tick();
      tick();
      tick();
      chk("rdrst_doe_pre", 8'(bus.d_oe), 8'h01);
      chreset = 1'b1;
      #5;
      chk("rdrst_doe", 8'(bus.d_oe), 8'h00);
      chk("rdrst_dout", bus.d_out, 8'h00);
      chk("rdrst_sfdbk", 8'(bus.cd_sfdbk), 8'h00);
      chk("rdrst_pos4", pos4, 8'h00);
      chk("rdrst_card_en", 8'(card_en), 8'h00);
      chreset = 1'b0;
      tick();
      chk("rdrst_hold_doe", 8'(bus.d_oe), 8'h00);
      bus_idle();
      tick();

      // Reset during a write data phase; the write must not commit
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd4, 8'h22, 8'h00);
      bus.cd_setup_l = 1'b0;
      bus.adl_l      = 1'b0;
      bus.s0_w_l     = 1'b0;
      bus.a          = 3'd4;
      bus.d_in       = 8'h5A;
      tick();
      bus.adl_l = 1'b1;
      bus.cmd   = 1'b1;
      tick();
      tick();
      chreset = 1'b1;
      #5;
      chk("wrst_pos4", pos4, 8'h00);
      chk("wrst_doe", 8'(bus.d_oe), 8'h00);
      chk("wrst_sfdbk", 8'(bus.cd_sfdbk), 8'h00);
      chreset = 1'b0;
      tick();
      chk("wrst_sfdbk_done", 8'(bus.cd_sfdbk), 8'h00);
      bus.cmd = 1'b0;
      tick();
      chk("wrst_no_stb", 8'(wr_stb), 8'h00);
      chk("wrst_pos4_after", pos4, 8'h00);
      bus_idle();
      tick();

      // Normal operation after reset
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
      pos_cycle(1'b0, 1'b1, 1'b0, 3'd5, 8'h3C, 8'h00);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 8'h3C);
      pos_cycle(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
